div_seq: RTL and testbench



---
 rtl/div_pkg.sv | 20 ++
 rtl/div_seq_if.sv | 28 ++
 rtl/div_step.sv | 38 +++
 rtl/div_seq.sv | 167 ++++++++++++++++
 tb/tb_div_seq.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the iterative divider: FSM state encodings,
// handshake level constants and the default datapath widths.
package div_pkg;

  localparam int DIV_DATA_W = 32;
  localparam int DIV_CNT_W  = 6;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;

endpackage

// File: rtl/div_seq_if.sv
// EX-to-divider handshake bundle. EX drives the request side (master),
// the divider drives result, ready and stall (slave).
interface div_seq_if
  import div_pkg::*;
#(
  parameter int DATA_W = DIV_DATA_W
) ();

  logic                  signed_div_i;
  logic [DATA_W-1:0]     opdata1_i;
  logic [DATA_W-1:0]     opdata2_i;
  logic                  start_i;
  logic                  annul_i;
  logic [2*DATA_W-1:0]   result_o;
  logic                  ready_o;
  logic                  stallreq_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o, stallreq_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o, stallreq_o
  );

endinterface

// File: rtl/div_step.sv
// One restoring-division step: shift {rem,quo} left by one and subtract the
// divisor magnitude from the partial remainder when it fits.
module div_step
  import div_pkg::*;
#(
  parameter int DATA_W = DIV_DATA_W
) (
  input  logic [DATA_W-1:0] rem_s,
  input  logic [DATA_W-1:0] quo_s,
  input  logic [DATA_W-1:0] divisor_s,
  output logic [DATA_W-1:0] rem_nxt_s,
  output logic [DATA_W-1:0] quo_nxt_s
);

  logic [DATA_W:0]   shifted_s;
  logic [DATA_W-1:0] rem_trial_s;
  logic              fits_s;

  // Keep the bit shifted out of rem so the fit test is exact at full width;
  // when it fits, the true difference is below 2^DATA_W so a modular subtract suffices.
  assign shifted_s   = {rem_s, quo_s[DATA_W-1]};
  assign fits_s      = (shifted_s >= {1'b0, divisor_s});
  assign rem_trial_s = shifted_s[DATA_W-1:0] - divisor_s;

  // Select restored or reduced remainder and set the new quotient bit.
  always_comb begin
    rem_nxt_s = shifted_s[DATA_W-1:0];
    quo_nxt_s = {quo_s[DATA_W-2:0], 1'b0};
    if (fits_s) begin
      rem_nxt_s = rem_trial_s;
      quo_nxt_s = {quo_s[DATA_W-2:0], 1'b1};
    end else begin
      rem_nxt_s = shifted_s[DATA_W-1:0];
      quo_nxt_s = {quo_s[DATA_W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_seq.sv
// Iterative signed/unsigned restoring divider sequencer for DIV/DIVU (HI/LO).
// Optional DIV_EARLY_EXIT_EN: finish in two cycles when |dividend| < |divisor|.
module div_seq
  import div_pkg::*;
#(
  parameter int DATA_W = DIV_DATA_W,
  parameter int CNT_W  = DIV_CNT_W
) (
  input  logic        clk,
  input  logic        rst,
  div_seq_if.slave    bus
);

  localparam logic [CNT_W-1:0]  LastCnt = CNT_W'(DATA_W - 1);
  localparam logic [DATA_W-1:0] ZeroW   = {DATA_W{1'b0}};

  div_state_e              state_r, state_nxt_s;
  logic [DATA_W-1:0]       rem_r, rem_nxt_s;
  logic [DATA_W-1:0]       quo_r, quo_nxt_s;
  logic [DATA_W-1:0]       divisor_r, divisor_nxt_s;
  logic                    sign1_r, sign1_nxt_s;
  logic                    sign2_r, sign2_nxt_s;
  logic [CNT_W-1:0]        cnt_r, cnt_nxt_s;
  logic [2*DATA_W-1:0]     result_r, result_nxt_s;
  logic                    ready_r, ready_nxt_s;
  logic                    stallreq_s;

  logic                    accept_s;
  logic                    stop_s;
  logic                    op1_neg_s, op2_neg_s;
  logic [DATA_W-1:0]       op1_mag_s, op2_mag_s;
  logic [DATA_W-1:0]       rem_step_s, quo_step_s;

  function automatic logic [DATA_W-1:0] neg2(input logic [DATA_W-1:0] v);
    return ~v + {{(DATA_W-1){1'b0}}, 1'b1};
  endfunction

  assign accept_s  = (bus.start_i == DivStart) & ~bus.annul_i;
  assign stop_s    = (bus.start_i == DivStop) | bus.annul_i;
  assign op1_neg_s = bus.signed_div_i & bus.opdata1_i[DATA_W-1];
  assign op2_neg_s = bus.signed_div_i & bus.opdata2_i[DATA_W-1];
  assign op1_mag_s = op1_neg_s ? neg2(bus.opdata1_i) : bus.opdata1_i;
  assign op2_mag_s = op2_neg_s ? neg2(bus.opdata2_i) : bus.opdata2_i;

  div_step #(.DATA_W(DATA_W)) u_step (
    .rem_s     (rem_r),
    .quo_s     (quo_r),
    .divisor_s (divisor_r),
    .rem_nxt_s (rem_step_s),
    .quo_nxt_s (quo_step_s)
  );

  // Next-state, datapath and output decode for the divider FSM.
  always_comb begin
    state_nxt_s   = state_r;
    rem_nxt_s     = rem_r;
    quo_nxt_s     = quo_r;
    divisor_nxt_s = divisor_r;
    sign1_nxt_s   = sign1_r;
    sign2_nxt_s   = sign2_r;
    cnt_nxt_s     = cnt_r;
    result_nxt_s  = result_r;
    ready_nxt_s   = ready_r;
    stallreq_s    = 1'b0;
    case (state_r)
      DivFree: begin
        stallreq_s = accept_s;
        if (accept_s) begin
          if (bus.opdata2_i == ZeroW) begin
            state_nxt_s = DivByZero;
            rem_nxt_s   = ZeroW;
            quo_nxt_s   = ZeroW;
          end
`ifdef DIV_EARLY_EXIT_EN
          else if (op1_mag_s < op2_mag_s) begin
            // Quotient is zero and the remainder is the dividend, sign included.
            state_nxt_s = DivByZero;
            rem_nxt_s   = bus.opdata1_i;
            quo_nxt_s   = ZeroW;
          end
`endif
          else begin
            state_nxt_s   = DivOn;
            rem_nxt_s     = ZeroW;
            quo_nxt_s     = op1_mag_s;
            divisor_nxt_s = op2_mag_s;
            sign1_nxt_s   = op1_neg_s;
            sign2_nxt_s   = op2_neg_s;
            cnt_nxt_s     = {CNT_W{1'b0}};
          end
        end else begin
          state_nxt_s = DivFree;
        end
      end
      DivByZero: begin
        stallreq_s  = 1'b1;
        state_nxt_s = DivEnd;
      end
      DivOn: begin
        stallreq_s = 1'b1;
        if (stop_s) begin
          state_nxt_s  = DivFree;
          result_nxt_s = {2*DATA_W{1'b0}};
          ready_nxt_s  = DivResultNotReady;
        end else begin
          rem_nxt_s = rem_step_s;
          quo_nxt_s = quo_step_s;
          cnt_nxt_s = cnt_r + CNT_W'(1);
          if (cnt_r == LastCnt) begin
            // Signed fix-up on entry to END: quotient by sign xor, remainder follows dividend.
            state_nxt_s = DivEnd;
            quo_nxt_s   = (sign1_r ^ sign2_r) ? neg2(quo_step_s) : quo_step_s;
            rem_nxt_s   = sign1_r ? neg2(rem_step_s) : rem_step_s;
          end else begin
            state_nxt_s = DivOn;
          end
        end
      end
      DivEnd: begin
        if (stop_s) begin
          state_nxt_s  = DivFree;
          result_nxt_s = {2*DATA_W{1'b0}};
          ready_nxt_s  = DivResultNotReady;
        end else begin
          state_nxt_s  = DivEnd;
          result_nxt_s = {rem_r, quo_r};
          ready_nxt_s  = DivResultReady;
        end
      end
      default: begin
        state_nxt_s  = DivFree;
        result_nxt_s = {2*DATA_W{1'b0}};
        ready_nxt_s  = DivResultNotReady;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= DivFree;
      rem_r     <= ZeroW;
      quo_r     <= ZeroW;
      divisor_r <= ZeroW;
      sign1_r   <= 1'b0;
      sign2_r   <= 1'b0;
      cnt_r     <= {CNT_W{1'b0}};
      result_r  <= {2*DATA_W{1'b0}};
      ready_r   <= DivResultNotReady;
    end else begin
      state_r   <= state_nxt_s;
      rem_r     <= rem_nxt_s;
      quo_r     <= quo_nxt_s;
      divisor_r <= divisor_nxt_s;
      sign1_r   <= sign1_nxt_s;
      sign2_r   <= sign2_nxt_s;
      cnt_r     <= cnt_nxt_s;
      result_r  <= result_nxt_s;
      ready_r   <= ready_nxt_s;
    end
  end

  assign bus.result_o   = result_r;
  assign bus.ready_o    = ready_r;
  assign bus.stallreq_o = stallreq_s;

endmodule

// File: tb/tb_div_seq.sv
// Directed self-checking bench for div_seq: latency, stall, signed fix-up,
// divide-by-zero, annul and reset behaviour with hand-computed results.
module tb_div_seq;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

`ifdef DIV_EARLY_EXIT_EN
  localparam int EarlyLat = 2;
`else
  localparam int EarlyLat = 33;
`endif

  always #5 clk = ~clk;

  div_seq_if #(.DATA_W(32)) bus ();

  div_seq #(.DATA_W(32), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation, measure latency and stall, check result and release.
  task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp_res, input int exp_lat);
    int lat = 0;
    int stall_hi = 0;
    bit done = 1'b0;
    bus.signed_div_i = sgn;
    bus.opdata1_i    = a;
    bus.opdata2_i    = b;
    bus.annul_i      = 1'b0;
    bus.start_i      = 1'b1;
    #1;
    check({tag, "/stall_accept"}, 64'(bus.stallreq_o), 64'd1);
    @(posedge clk);
    #1;
    bus.opdata1_i    = 32'hDEAD_BEEF;
    bus.opdata2_i    = 32'h0000_0000;
    bus.signed_div_i = ~sgn;
    for (int i = 0; i < 100 && !done; i++) begin
      if (bus.ready_o) begin
        done = 1'b1;
        lat  = i;
      end else begin
        if (bus.stallreq_o) stall_hi++;
        tick();
      end
    end
    check({tag, "/done"}, 64'(done), 64'd1);
    check({tag, "/latency"}, 64'(lat), 64'(exp_lat));
    check({tag, "/stall_cycles"}, 64'(stall_hi), 64'(exp_lat - 1));
    check({tag, "/stall_end"}, 64'(bus.stallreq_o), 64'd0);
    check({tag, "/result"}, bus.result_o, exp_res);
    tick();
    check({tag, "/result_held"}, {bus.result_o[62:0], bus.ready_o}, {exp_res[62:0], 1'b1});
    bus.start_i = 1'b0;
    tick();
    check({tag, "/ready_drop"}, 64'(bus.ready_o), 64'd0);
    check({tag, "/result_clr"}, bus.result_o, 64'd0);
  endtask

  initial begin
    int ready_seen;
    bit done;
    rst              = 1'b1;
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'd0;
    bus.opdata2_i    = 32'd0;
    bus.start_i      = 1'b0;
    bus.annul_i      = 1'b0;
    tick();
    tick();
    check("reset/result", bus.result_o, 64'd0);
    check("reset/ready", 64'(bus.ready_o), 64'd0);
    check("reset/stall", 64'(bus.stallreq_o), 64'd0);
    rst = 1'b0;
    tick();

    run_div("divu_100_7",   1'b0, 32'd100,        32'd7,          {32'd2, 32'd14}, 33);
    run_div("div_m7_2",     1'b1, 32'hFFFF_FFF9,  32'd2,          {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33);
    run_div("div_7_m2",     1'b1, 32'd7,          32'hFFFF_FFFE,  {32'd1, 32'hFFFF_FFFD}, 33);
    run_div("div_m7_m2",    1'b1, 32'hFFFF_FFF9,  32'hFFFF_FFFE,  {32'hFFFF_FFFF, 32'd3}, 33);
    run_div("divu_big_2",   1'b0, 32'hFFFF_FFF9,  32'd2,          {32'd1, 32'h7FFF_FFFC}, 33);
    run_div("divu_max",     1'b0, 32'hFFFF_FFFF,  32'h6000_0000,  {32'h3FFF_FFFF, 32'd2}, 33);
    run_div("divu_5_0",     1'b0, 32'd5,          32'd0,          64'd0, 2);
    run_div("div_min_m1",   1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  {32'd0, 32'h8000_0000}, 33);
    run_div("divu_9_3",     1'b0, 32'd9,          32'd3,          {32'd0, 32'd3}, 33);
    run_div("divu_5_9",     1'b0, 32'd5,          32'd9,          {32'd5, 32'd0}, EarlyLat);

    // Annul at iteration 10: back to FREE, no result ever.
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'd1000;
    bus.opdata2_i    = 32'd3;
    bus.start_i      = 1'b1;
    tick();
    repeat (10) tick();
    check("annul/stall_on", 64'(bus.stallreq_o), 64'd1);
    bus.annul_i = 1'b1;
    tick();
    check("annul/stall_free", 64'(bus.stallreq_o), 64'd0);
    check("annul/result", bus.result_o, 64'd0);
    ready_seen = 0;
    repeat (40) begin
      if (bus.ready_o) ready_seen++;
      tick();
    end
    check("annul/ready_never", 64'(ready_seen), 64'd0);
    bus.start_i = 1'b0;
    bus.annul_i = 1'b0;
    tick();

    // Reset mid-ON clears everything on the next edge.
    bus.opdata1_i = 32'd100;
    bus.opdata2_i = 32'd7;
    bus.start_i   = 1'b1;
    tick();
    repeat (5) tick();
    rst         = 1'b1;
    bus.start_i = 1'b0;
    tick();
    check("rst_on/result", bus.result_o, 64'd0);
    check("rst_on/ready", 64'(bus.ready_o), 64'd0);
    check("rst_on/stall", 64'(bus.stallreq_o), 64'd0);
    rst = 1'b0;
    tick();

    // Reset while a result is held in END.
    bus.start_i = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      if (bus.ready_o) done = 1'b1;
      else tick();
    end
    check("rst_end/done", 64'(done), 64'd1);
    check("rst_end/pre_result", bus.result_o, {32'd2, 32'd14});
    rst = 1'b1;
    tick();
    check("rst_end/result", bus.result_o, 64'd0);
    check("rst_end/ready", 64'(bus.ready_o), 64'd0);
    bus.start_i = 1'b0;
    rst = 1'b0;
    tick();
    check("rst_end/idle_stall", 64'(bus.stallreq_o), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
